// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle add/sub/logic/slt/shift plus an iterative
// shift-add multiplier that holds its result until the consumer takes it.
`timescale 1ns/1ps
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int MUL_EN  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         alu_op,
   input  logic [5:0]         func,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic [WIDTH-1:0]   result_hi,
   output logic               zero,
   output logic               ovf,
   output logic               illegal,
   output logic               busy
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL, OP_SRA,
      OP_MULT, OP_MULTU, OP_ILL
   } op_t;

   state_t state;
   op_t    op;

   logic                    accept;
   logic                    is_mul;
   logic                    mul_signed;
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic [WIDTH-1:0]        sum;
   logic [WIDTH-1:0]        diff;
   logic                    add_ovf;
   logic                    sub_ovf;
   logic [WIDTH-1:0]        alu_res;
   logic                    alu_ovf;
   logic                    alu_ill;

   logic [WIDTH-1:0]        mcand;
   logic [WIDTH-1:0]        acc_hi;
   logic [WIDTH-1:0]        acc_lo;
   logic                    neg;
   logic [CNT_W-1:0]        cnt;
   logic [WIDTH:0]          step_sum;
   logic [2*WIDTH-1:0]      step_prod;
   logic [2*WIDTH-1:0]      mul_final;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic sgn);
      if (sgn && v[WIDTH-1]) return ~v + WIDTH'(1);
      return v;
   endfunction

   always_comb begin
      op = OP_ILL;
      case (alu_op)
         3'b000: op = OP_ADD;
         3'b001: op = OP_SUB;
         3'b100: op = OP_AND;
         3'b101: op = OP_OR;
         3'b010, 3'b011: begin
            case (func)
               FN_ADD:   op = OP_ADD;
               FN_SUB:   op = OP_SUB;
               FN_AND:   op = OP_AND;
               FN_OR:    op = OP_OR;
               FN_SLT:   op = OP_SLT;
               FN_SLL:   op = OP_SLL;
               FN_SRL:   op = OP_SRL;
               FN_SRA:   op = OP_SRA;
               FN_MULT:  op = (MUL_EN != 0) ? OP_MULT : OP_ILL;
               FN_MULTU: op = (MUL_EN != 0) ? OP_MULTU : OP_ILL;
               default:  op = OP_ILL;
            endcase
         end
         default: op = OP_ILL;
      endcase
   end

   assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
   assign mul_signed = (op == OP_MULT);
   assign busy       = (state == MUL);
   assign zero       = (result == '0);

   assign a_s     = $signed(op_a);
   assign b_s     = $signed(op_b);
   assign sum     = op_a + op_b;
   assign diff    = op_a - op_b;
   assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
   assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (op)
         OP_ADD: begin alu_res = sum;  alu_ovf = add_ovf; end
         OP_SUB: begin alu_res = diff; alu_ovf = sub_ovf; end
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_SLL:  alu_res = op_b << shamt;
         OP_SRL:  alu_res = op_b >> shamt;
         OP_SRA:  alu_res = b_s >>> shamt;
         OP_ILL:  alu_ill = 1'b1;
         default: alu_res = '0;
      endcase
   end

   // One multiplier bit per cycle on magnitudes; the sign is restored on the last step
   assign step_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
   assign step_prod = {step_sum, acc_lo[WIDTH-1:1]};
   assign mul_final = neg ? (~step_prod + (2*WIDTH)'(1)) : step_prod;

   always_ff @(posedge clk) begin
      if (accept && is_mul) begin
         mcand  <= magnitude(op_a, mul_signed);
         acc_lo <= magnitude(op_b, mul_signed);
         acc_hi <= '0;
         neg    <= mul_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      end else if (state == MUL) begin
         {acc_hi, acc_lo} <= step_prod;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         ovf       <= 1'b0;
         illegal   <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && is_mul) begin
                  state     <= MUL;
                  out_valid <= 1'b0;
                  cnt       <= CNT_W'(WIDTH-1);
               end else if (accept) begin
                  out_valid <= 1'b1;
                  result    <= alu_res;
                  result_hi <= '0;
                  ovf       <= alu_ovf;
                  illegal   <= alu_ill;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            MUL: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
                  result    <= mul_final[WIDTH-1:0];
                  result_hi <= mul_final[2*WIDTH-1:WIDTH];
                  ovf       <= 1'b0;
                  illegal   <= 1'b0;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus random traffic scored
// against a cycle-level behavioural model using 64-bit arithmetic.
`timescale 1ns/1ps
module tb_alu_exec_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [2:0]    alu_op = 3'b000;
   logic [5:0]    func = 6'b0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic [4:0]    shamt = '0;
   logic          in_ready, out_valid, zero, ovf, illegal, busy;
   logic [W-1:0]  result, result_hi;
   logic          in_ready0, out_valid0, zero0, ovf0, illegal0, busy0;
   logic [W-1:0]  result0, result_hi0;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(W), .SHAMT_W(5), .MUL_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .func(func), .op_a(op_a), .op_b(op_b), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .result_hi(result_hi), .zero(zero), .ovf(ovf), .illegal(illegal), .busy(busy));

   alu_exec_unit #(.WIDTH(W), .SHAMT_W(5), .MUL_EN(0)) dut_nomul (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .alu_op(alu_op), .func(func), .op_a(op_a), .op_b(op_b), .shamt(shamt),
      .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
      .result_hi(result_hi0), .zero(zero0), .ovf(ovf0), .illegal(illegal0), .busy(busy0));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference semantics of one operation, straight from the op table
   function automatic void ref_op(input logic [2:0] aop, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, input bit mul_en,
                                  output bit is_mul, output logic [31:0] lo,
                                  output logic [31:0] hi, output bit ov, output bit il);
      longint sa, sb, s, lim;
      logic [63:0] p;
      int k;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lim = 64'sd2147483648;
      k = -1;
      case (aop)
         3'd0: k = 0;
         3'd1: k = 1;
         3'd4: k = 2;
         3'd5: k = 3;
         3'd2, 3'd3: begin
            case (fn)
               6'h20: k = 0;
               6'h22: k = 1;
               6'h24: k = 2;
               6'h25: k = 3;
               6'h2A: k = 4;
               6'h00: k = 5;
               6'h02: k = 6;
               6'h03: k = 7;
               6'h18: k = mul_en ? 8 : -1;
               6'h19: k = mul_en ? 9 : -1;
               default: k = -1;
            endcase
         end
         default: k = -1;
      endcase
      is_mul = (k == 8) || (k == 9);
      lo = '0; hi = '0; ov = 1'b0; il = (k == -1);
      case (k)
         0: begin s = sa + sb; lo = s[31:0]; ov = (s >= lim) || (s < -lim); end
         1: begin s = sa - sb; lo = s[31:0]; ov = (s >= lim) || (s < -lim); end
         2: lo = a & b;
         3: lo = a | b;
         4: lo = (sa < sb) ? 32'd1 : 32'd0;
         5: lo = b << sh;
         6: lo = b >> sh;
         7: begin s = sb >>> sh; lo = s[31:0]; end
         8: begin s = sa * sb; lo = s[31:0]; hi = s[63:32]; end
         9: begin p = {32'b0, a} * {32'b0, b}; lo = p[31:0]; hi = p[63:32]; end
         default: ;
      endcase
   endfunction

   // Cycle-level model of what the unit must be presenting
   bit          m_valid = 0, m_from_mul = 0, started = 0;
   int          mul_left = 0;
   logic [31:0] m_res = '0, m_hi = '0, p_lo = '0, p_hi = '0;
   bit          m_ovf = 0, m_ill = 0;
   bit          t_mul, t_ov, t_il;
   logic [31:0] t_lo, t_hi;

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 0; m_from_mul <= 0; mul_left <= 0;
         m_res <= '0; m_hi <= '0; m_ovf <= 0; m_ill <= 0;
      end else if (mul_left > 0) begin
         mul_left <= mul_left - 1;
         if (mul_left == 1) begin
            m_valid <= 1; m_from_mul <= 1; m_res <= p_lo; m_hi <= p_hi;
            m_ovf <= 0; m_ill <= 0;
         end
      end else if (m_from_mul) begin
         if (out_ready) begin m_valid <= 0; m_from_mul <= 0; end
      end else if (in_valid && (!m_valid || out_ready)) begin
         ref_op(alu_op, func, op_a, op_b, shamt, 1'b1, t_mul, t_lo, t_hi, t_ov, t_il);
         if (t_mul) begin
            mul_left <= W; m_valid <= 0; p_lo <= t_lo; p_hi <= t_hi;
         end else begin
            m_valid <= 1; m_res <= t_lo; m_hi <= t_hi; m_ovf <= t_ov; m_ill <= t_il;
         end
      end else if (m_valid && out_ready) begin
         m_valid <= 0;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", in_ready, (mul_left == 0 && !m_from_mul) && (!m_valid || out_ready));
         chk("out_valid", out_valid, m_valid);
         chk("busy", busy, mul_left > 0);
         chk("busy_nomul", busy0, 1'b0);
         if (m_valid) begin
            chk("result", result, m_res);
            chk("result_hi", result_hi, m_hi);
            chk("zero", zero, m_res == 0);
            chk("ovf", ovf, m_ovf);
            chk("illegal", illegal, m_ill);
         end
      end
   end

   task automatic issue(input logic [2:0] aop, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      int guard;
      @(posedge clk); #1;
      alu_op = aop; func = fn; op_a = a; op_b = b; shamt = sh; in_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic mul_test(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n, busy_n;
      issue(3'b010, fn, a, b, 5'd0);
      n = 0; busy_n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (n == 1 && fn == 6'h18) begin
            chk("nomul_illegal", illegal0, 1'b1);
            chk("nomul_result", result0, 32'd0);
         end
         if (busy) busy_n++;
         if (out_valid) break;
      end
      chk("mul_latency", n, 33);
      chk("mul_busy_cycles", busy_n, 32);
      chk("mul_hi", result_hi, exp_hi);
      chk("mul_lo", result, exp_lo);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   logic [5:0] fn_tab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h18, 6'h19};

   initial begin
      bit          p_mul, p_ov, p_il;
      logic [31:0] p_l, p_h, held;
      bit          stable;
      int          r;

      // Pin the reference model to hand-worked values
      ref_op(3'b010, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b1, p_mul, p_l, p_h, p_ov, p_il);
      chk("model_add_ovf", {p_ov, p_l}, {1'b1, 32'h80000000});
      ref_op(3'b010, 6'h03, 32'h0, 32'h80000010, 5'd4, 1'b1, p_mul, p_l, p_h, p_ov, p_il);
      chk("model_sra", p_l, 32'hF8000001);
      ref_op(3'b010, 6'h18, 32'hFFFFFFFE, 32'h3, 5'd0, 1'b1, p_mul, p_l, p_h, p_ov, p_il);
      chk("model_mult", {p_h, p_l}, 64'hFFFFFFFF_FFFFFFFA);
      ref_op(3'b010, 6'h19, 32'hFFFFFFFE, 32'h3, 5'd0, 1'b1, p_mul, p_l, p_h, p_ov, p_il);
      chk("model_multu", {p_h, p_l}, 64'h00000002_FFFFFFFA);

      @(posedge clk); #1 started = 1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, 32'd0);
      chk("rst_result_hi", result_hi, 32'd0);
      chk("rst_zero", zero, 1'b1);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_illegal", illegal, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk); #1 rst = 1'b0;

      issue(3'b010, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd0);
      @(negedge clk);
      chk("add_ovf_result", result, 32'h80000000);
      chk("add_ovf_flag", ovf, 1'b1);
      chk("add_ovf_zero", zero, 1'b0);

      issue(3'b010, 6'h03, 32'h0, 32'h80000010, 5'd4);
      @(negedge clk);
      chk("sra_result", result, 32'hF8000001);
      issue(3'b010, 6'h2A, 32'hFFFFFFFF, 32'h0, 5'd0);
      @(negedge clk);
      chk("slt_result", result, 32'd1);

      issue(3'b010, 6'h3F, 32'h1234, 32'h5678, 5'd0);
      @(negedge clk);
      chk("illegal_flag", illegal, 1'b1);
      chk("illegal_result", result, 32'd0);
      chk("illegal_zero", zero, 1'b1);

      mul_test(6'h18, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
      mul_test(6'h19, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
      mul_test(6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

      // Backpressure: held result stays put while a new op waits
      issue(3'b000, 6'h0, 32'd10, 32'd20, 5'd0);
      out_ready = 1'b0;
      alu_op = 3'b001; op_a = 32'd50; op_b = 32'd8; in_valid = 1'b1;
      @(negedge clk);
      held = result;
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== held) stable = 0;
         @(negedge clk);
      end
      chk("hold_stable", stable, 1'b1);
      chk("hold_value", held, 32'd30);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      alu_op = 3'b101; op_a = 32'hF0; op_b = 32'h0F;
      @(negedge clk);
      chk("b2b_first_valid", out_valid, 1'b1);
      chk("b2b_first_result", result, 32'd42);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_second_valid", out_valid, 1'b1);
      chk("b2b_second_result", result, 32'hFF);

      // Reset in the middle of a multiply
      issue(3'b010, 6'h19, 32'd123, 32'd456, 5'd0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      issue(3'b000, 6'h0, 32'd3, 32'd4, 5'd0);
      @(negedge clk);
      chk("post_abort_add", result, 32'd7);

      // Random traffic, scored by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rst       = ($urandom_range(0, 399) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 4) != 0);
         op_a      = rand_operand();
         op_b      = rand_operand();
         shamt     = 5'($urandom);
         r         = int'($urandom_range(0, 15));
         func      = fn_tab[$urandom_range(0, 9)];
         case (r)
            0: alu_op = 3'b000;
            1: alu_op = 3'b001;
            2: alu_op = 3'b100;
            3: alu_op = 3'b101;
            4: alu_op = {2'b11, 1'($urandom)};
            5: begin alu_op = 3'b010; func = 6'($urandom); end
            default: alu_op = {2'b01, 1'($urandom)};
         endcase
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter SHAMT_W, default 5, meaning shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 SHALL have parameter MUL_EN, default 1, meaning 1 = mult/multu implemented, 0 = treated as illegal.
REQ-004 Ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation present.
- in_ready  out  1  unit can accept.
- alu_op  in  3  main-decoder op class.
- func  in  6  R-type function field.
- op_a  in  WIDTH  rs operand.
- op_b  in  WIDTH  rt/immediate operand.
- shamt  in  SHAMT_W  shift amount.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  low result.
- result_hi  out  WIDTH  high product, else 0.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow (add/sub only).
- illegal  out  1  undecodable alu_op/func.
- busy  out  1  multiply in progress.

Function
REQ-005 Decode: alu_op 000 add; 001 sub; 100 and; 101 or; 01x uses func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 000010 srl, 000011 sra, 011000 mult, 011001 multu; any other combination sets illegal.
REQ-006 Add/sub SHALL wrap modulo 2^WIDTH; ovf = signed overflow of that add/sub; ovf = 0 for all other ops.
REQ-007 slt SHALL give 1 if signed op_a < signed op_b, else 0, zero-extended to WIDTH.
REQ-008 Shifts SHALL shift op_b by shamt; sll/srl zero-fill, sra sign-fills from op_b[WIDTH-1].
REQ-009 Illegal ops SHALL complete single-cycle with result = 0, result_hi = 0, illegal = 1.
REQ-010 Handshake: transfer on in_valid && in_ready; in_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-011 Single-cycle op accepted at edge N: result, flags, out_valid = 1 registered at edge N.
REQ-012 FSM states IDLE, MUL, HOLD.
- IDLE -> MUL on accepted mult/multu.
- MUL -> HOLD after exactly WIDTH iteration cycles.
- HOLD -> IDLE when out_valid && out_ready.
- Single-cycle ops stay in IDLE.
REQ-013 Multiply SHALL be iterative shift-add, one partial-product bit per cycle; operands latched at acceptance.
- mult: signed 2WIDTH-bit product, via operand magnitudes and final conditional negate inside the WIDTH cycles.
- multu: unsigned product.
- Accepted at edge N -> out_valid = 1 at edge N+WIDTH; result = low half, result_hi = high half.
REQ-014 busy = 1 exactly while state == MUL; in_ready = 0 in MUL and HOLD.
REQ-015 Held outputs SHALL remain stable while out_valid && !out_ready.
REQ-016 out_valid && out_ready with no new acceptance in the same cycle SHALL clear out_valid next edge; with a single-cycle acceptance in the same cycle, the new result replaces it with no bubble.
REQ-017 zero SHALL be computed from the registered result (low half only).
REQ-018 Input changes while in_ready = 0 SHALL have no effect.

Reset
REQ-019 rst high at an edge: state = IDLE, out_valid = 0, result = 0, result_hi = 0, zero = 1, ovf = 0, illegal = 0, busy = 0.
REQ-020 rst during MUL or HOLD SHALL abort the operation with no output produced; in_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-021 WIDTH=32, alu_op=010, func=100000, op_a=0x7FFFFFFF, op_b=1, out_ready=1 -> next cycle result=0x80000000, ovf=1, zero=0.
REQ-022 alu_op=010, func=000011, op_b=0x80000010, shamt=4 -> result=0xF8000001; then func=101010, op_a=0xFFFFFFFF, op_b=0 -> result=1.
REQ-023 mult op_a=0xFFFFFFFE (-2), op_b=3 accepted at edge N -> busy for 32 cycles, out_valid at N+32, result_hi=0xFFFFFFFF, result=0xFFFFFFFA; multu on same operands -> result_hi=0x00000002, result=0xFFFFFFFA.
REQ-024 out_ready=0 with a result held, in_valid=1 -> in_ready=0, outputs stable for 10 cycles; raise out_ready -> pending op accepted that cycle, back-to-back single-cycle results with no bubble.
REQ-025 alu_op=010, func=111111 -> illegal=1, result=0, zero=1; with MUL_EN=0, func=011000 -> illegal=1, busy stays 0.
REQ-026 rst asserted 5 cycles into a multiply -> out_valid=0, busy=0 after the edge; a following add 3+4 returns result=7.
